fifo_uart_tx: RTL

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 17 +
 rtl/fifo_uart_tx_baud_tick.sv | 29 ++
 rtl/fifo_uart_tx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for fifo_uart_tx: frame width and FSM state encoding.
// Optional feature macro: FIFO_UART_TX_PARITY_EN adds the PARITY state.
package fifo_uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, STOP
    } state_t;
`endif

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// baud_tick: bit-period timer. Counts 0..CLKS_PER_BIT-1 and pulses tick on
// the last cycle of each bit, wrapping to 0 so every bit boundary restarts it.
// clr holds the counter at 0 while no bit is on the line.
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign tick = !clr && (cnt == LAST);

    // Free-running bit counter, restarted on clear and on every bit boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls bytes from an upstream FIFO and serialises them as
// 8N1/8N2 UART frames (start, 8 data bits LSB first, STOP_BITS stop bits).
// Optional feature macro: FIFO_UART_TX_PARITY_EN inserts an even-parity bit
// between the data and stop bits.
// Back-to-back frames are separated by exactly the FETCH and LOAD cycles.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       rd_en,
    output logic       tx,
    output logic       busy,
    output logic [7:0] tx_count
);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           bit_idx;
    logic                 tick;
    logic                 timer_clr;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                 parity;
`endif

    // The timer only runs while a bit is on the line
    assign timer_clr = (state == IDLE) || (state == FETCH) || (state == LOAD);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .tick (tick)
    );

    // Read strobe lives only in FETCH and is masked by the empty flag so the
    // FIFO is never popped while empty
    assign rd_en = (state == FETCH) && !fifo_empty;
    assign busy  = (state != IDLE);

    // Frame sequencer; tx is set on each transition so it is a pure register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_count <= 8'd0;
            shreg    <= '0;
            bit_idx  <= 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty)
                        state <= FETCH;
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg   <= fifo_dout;
                    bit_idx <= 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity  <= ^fifo_dout;
`endif
                    tx      <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                            tx      <= parity;
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                            tx      <= shreg[1];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    // bit_idx counts stop bits here
                    if (tick) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx  <= 3'd0;
                            tx_count <= tx_count + 8'd1;
                            state    <= fifo_empty ? IDLE : FETCH;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
